uc_arbiter: RTL and testbench
=============================

Name: uc_arbiter

Overview:
- Unit-clause arbiter and queue (UCQ) between the BCP PE array and the PEs' new-literal input.
- Collects implications and conflicts from NUM_PE BCP engines plus decision literals from the decider.
- Serialises them round-robin into a FIFO and broadcasts the head literal to all PEs.
- The head is popped only when every PE has accepted it.

Parameters:
- NUM_PE, 4, number of BCP PEs feeding and consuming the queue.
- UCQ_DEPTH, 16, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pe_imply_valid  in  NUM_PE  per-PE implication strobe
- pe_imply_lit  in  NUM_PE x lit_t  per-PE implied literal (signed; 0 is illegal)
- pe_conflict  in  NUM_PE  per-PE conflict strobe
- pe_imply_ready  out  NUM_PE  per-PE pending slot empty
- dec_lit  in  lit_t  decision literal
- dec_valid  in  1  decision valid
- dec_ready  out  1  decision accepted this cycle
- ucarb2bcp_newLit  out  lit_t  head literal, broadcast to all PEs
- ucarb2bcp_newLitValid  out  1  FIFO non-empty and no conflict
- bcp2ucarb_newLitAccept  in  NUM_PE  per-PE accept
- flush  in  1  backtrack: clear all state
- conflict_o  out  1  sticky conflict flag
- ucq_count  out  clog2(UCQ_DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, pending slots empty, RR pointer 0.
  - conflict_o=0, newLitValid=0, newLit=0, pe_imply_ready all 1, dec_ready=0, ucq_count=0.
- Capture: pe_imply_valid[i] && pe_imply_ready[i] latches the literal into pending[i] at the edge; pe_imply_ready[i] = !pending_valid[i].
- Arbitration, one enqueue per cycle:
  - Round-robin over pending slots, starting at the RR pointer.
  - RR pointer advances to winner+1 (mod NUM_PE) after a grant.
  - Decision literal is lowest priority: dec_ready=1 only when no pending slot is valid, FIFO not full, and conflict_o=0.
- Enqueue condition: !full || pop in the same cycle (full with a simultaneous pop accepts the push).
- Pop = newLitValid && (&bcp2ucarb_newLitAccept); the pointer advances at the edge.
- Latency, empty queue: imply_valid at cycle t -> pending at t+1 -> enqueued at t+1 edge -> newLitValid at t+2. No bypass path.
- newLit is driven from the registered FIFO head; its value is 0 when empty.
- Conflict: any pe_conflict bit at an edge sets conflict_o.
  - While conflict_o=1: FIFO and pendings are cleared; pe_imply_ready=0; newLitValid=0; dec_ready=0.
  - conflict_o holds until flush.
  - Conflict in the same cycle as an implication: the conflict wins and the implication is dropped.
- flush (synchronous, single cycle): clears FIFO, pendings, conflict_o and RR pointer.
  - flush has priority over every push, pop or conflict in that cycle.
  - Outputs read as reset values on the following cycle.
- Occupancy: ucq_count = entries. Pointers wrap modulo UCQ_DEPTH; a pointer-plus-count scheme distinguishes full from empty.
- Illegal literal: lit=0 on an implication or decision is dropped and never enqueued.

Optional Feature:
- Macro: UCARB_DEDUP_EN.
- Enabled: before enqueue, the winning literal is compared against all valid FIFO entries and the current head.
  - Identical literal: discarded. The pending slot is still freed and the RR pointer still advances.
  - Negated literal (lit == -entry): sets conflict_o exactly as a PE conflict does.
- Disabled: no comparison; every literal is enqueued, and contradiction is left to the PEs and the global state table.

Decomposition:
- Shared package holds:
  - lit_t, UCQ_DEPTH default, NUM_PE default.
  - An ucq_entry_t struct (lit, valid).
  - A lit_neg function (two's-complement negate).
- One natural sub-module: ucq_fifo (parameterised synchronous FIFO with count, full, empty and clear).
- Arbiter, pending slots and dedup logic stay in uc_arbiter.

Test Plan:
- PE1 implies +5 at t=0, all accepts high -> newLitValid=1, newLit=+5 at t=2; empty again at t=3.
- PE0..PE3 imply +1,+2,+3,+4 in the same cycle, RR pointer at 2 -> output order +3,+4,+1,+2; each ready returns high the cycle after its grant.
- FIFO full (16), accept held low except PE2 -> no pop, pe_imply_ready drops once pendings fill. Then all accepts high and PE0 implies +9 -> push and pop in the same cycle, count stays 16.
- pe_conflict[3] pulse with queue holding 5 entries -> conflict_o=1 next cycle, count=0, newLitValid=0. Then flush -> conflict_o=0 and ready all 1.
- dec_valid with dec_lit=-7 while PE0 implies +8 -> +8 enqueued first and dec_ready=1 one cycle later; dec_lit=0 -> dropped.
- UCARB_DEDUP_EN: queue holds +4, PE1 implies +4 -> count unchanged. PE2 then implies -4 -> conflict_o=1. Without the macro: both enqueued, no conflict.

Source files
------------

// File: rtl/uc_arbiter_pkg.sv
// uc_arbiter_pkg: literal type, queue entry and defaults shared by the unit-clause arbiter
package uc_arbiter_pkg;
  localparam int LIT_W = 16;
  localparam int DEF_NUM_PE = 4;
  localparam int DEF_UCQ_DEPTH = 16;
  typedef logic signed [LIT_W-1:0] lit_t;
  typedef struct packed {
    lit_t lit;
    logic valid;
  } ucq_entry_t;
  function automatic lit_t lit_neg(lit_t l);
    return -l;
  endfunction
endpackage

// File: rtl/ucq_fifo.sv
// ucq_fifo: literal FIFO with read pointer plus count, clear, and an entry view under UCARB_DEDUP_EN
module ucq_fifo import uc_arbiter_pkg::*; #(
  parameter int DEPTH = DEF_UCQ_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  lit_t        din,
  input  logic        pop,
  output lit_t        head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
`ifdef UCARB_DEDUP_EN
  , output ucq_entry_t entries [DEPTH]
`endif
);
  lit_t r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  logic [AW-1:0] w_wr;
  assign full = r_cnt == (AW+1)'(DEPTH);
  assign empty = r_cnt == '0;
  assign count = r_cnt;
  assign head = empty ? '0 : r_mem[r_rd];
  assign w_push = push && (!full || pop);
  assign w_pop = pop && !empty;
  assign w_wr = r_rd + r_cnt[AW-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push && !clr) r_mem[w_wr] <= din;
`ifdef UCARB_DEDUP_EN
  always_comb
    for (int i = 0; i < DEPTH; i++) begin
      entries[i].lit = r_mem[i];
      entries[i].valid = {1'b0, AW'(i) - r_rd} < r_cnt;
    end
`endif
endmodule

// File: rtl/uc_arbiter.sv
// uc_arbiter: round-robin unit-clause arbiter feeding a broadcast FIFO; UCARB_DEDUP_EN drops repeats and flags contradictions
module uc_arbiter import uc_arbiter_pkg::*; #(
  parameter int NUM_PE = DEF_NUM_PE,
  parameter int UCQ_DEPTH = DEF_UCQ_DEPTH,
  localparam int CW = $clog2(UCQ_DEPTH) + 1,
  localparam int RW = NUM_PE > 1 ? $clog2(NUM_PE) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PE-1:0] pe_imply_valid,
  input  lit_t              pe_imply_lit [NUM_PE],
  input  logic [NUM_PE-1:0] pe_conflict,
  output logic [NUM_PE-1:0] pe_imply_ready,
  input  lit_t              dec_lit,
  input  logic              dec_valid,
  output logic              dec_ready,
  output lit_t              ucarb2bcp_newLit,
  output logic              ucarb2bcp_newLitValid,
  input  logic [NUM_PE-1:0] bcp2ucarb_newLitAccept,
  input  logic              flush,
  output logic              conflict_o,
  output logic [CW-1:0]     ucq_count
);
  logic [NUM_PE-1:0] r_pend_valid;
  lit_t r_pend_lit [NUM_PE];
  logic [RW-1:0] r_rr;
  logic r_conflict;
  logic [NUM_PE-1:0] w_cap;
  logic [RW-1:0] w_win, w_idx, w_rr_next;
  logic w_full, w_empty, w_pop, w_room, w_any, w_grant, w_dec_take, w_cand_valid;
  logic w_dup, w_neg, w_conf_in, w_clr, w_push;
  lit_t w_cand, w_head;
`ifdef UCARB_DEDUP_EN
  ucq_entry_t w_entries [UCQ_DEPTH];
`endif
  // scan downward so the slot closest to the RR pointer is the last (winning) assignment
  always_comb begin
    w_win = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      w_idx = RW'((int'(r_rr) + k) % NUM_PE);
      if (r_pend_valid[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
  end
  always_comb
    for (int i = 0; i < NUM_PE; i++)
      w_cap[i] = pe_imply_valid[i] && pe_imply_ready[i] && pe_imply_lit[i] != '0;
  assign w_rr_next = (w_win == RW'(NUM_PE - 1)) ? '0 : w_win + RW'(1);
  assign w_pop = ucarb2bcp_newLitValid && &bcp2ucarb_newLitAccept;
  assign w_room = !w_full || w_pop;
  assign w_grant = w_any && w_room && !r_conflict;
  assign dec_ready = rst_n && !w_any && !w_full && !r_conflict;
  assign w_dec_take = dec_valid && dec_ready && dec_lit != '0;
  assign w_cand = w_any ? r_pend_lit[w_win] : dec_lit;
  assign w_cand_valid = w_grant || w_dec_take;
`ifdef UCARB_DEDUP_EN
  always_comb begin
    w_dup = 1'b0;
    w_neg = 1'b0;
    for (int i = 0; i < UCQ_DEPTH; i++) begin
      w_dup = w_dup || (w_entries[i].valid && w_entries[i].lit == w_cand);
      w_neg = w_neg || (w_entries[i].valid && w_entries[i].lit == lit_neg(w_cand));
    end
  end
`else
  assign w_dup = 1'b0;
  assign w_neg = 1'b0;
`endif
  assign w_conf_in = |pe_conflict || (w_cand_valid && w_neg);
  assign w_clr = flush || r_conflict || w_conf_in;
  assign w_push = w_cand_valid && !w_dup && !w_neg;
  assign pe_imply_ready = ~r_pend_valid & {NUM_PE{!r_conflict}};
  assign ucarb2bcp_newLitValid = !w_empty && !r_conflict;
  assign ucarb2bcp_newLit = w_head;
  assign conflict_o = r_conflict;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pend_valid <= '0;
      r_rr <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= !flush && (r_conflict || w_conf_in);
      r_rr <= flush ? '0 : w_grant ? w_rr_next : r_rr;
      for (int i = 0; i < NUM_PE; i++)
        r_pend_valid[i] <= w_clr ? 1'b0 : (w_grant && w_win == RW'(i)) ? 1'b0 : w_cap[i] || r_pend_valid[i];
    end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_PE; i++)
      if (w_cap[i]) r_pend_lit[i] <= pe_imply_lit[i];
  ucq_fifo #(.DEPTH(UCQ_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(w_clr),
    .push(w_push),
    .din(w_cand),
    .pop(w_pop),
    .head(w_head),
    .full(w_full),
    .empty(w_empty),
    .count(ucq_count)
`ifdef UCARB_DEDUP_EN
    , .entries(w_entries)
`endif
  );
endmodule

// File: tb/tb_uc_arbiter.sv
// tb_uc_arbiter: directed scenarios plus randomized traffic checked against a queue-based model
module tb_uc_arbiter;
  import uc_arbiter_pkg::*;
  localparam int N = 4;
  localparam int D = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] iv, ic, acc, rdy;
  lit_t il [N];
  lit_t dl, nl;
  logic dv, fl, dr, nlv, conf;
  logic [4:0] cnt;
  logic [27:0] dut_vec;
  lit_t mq [$];
  logic [N-1:0] mpv;
  lit_t mpl [N];
  int mrr;
  bit mconf;
  int ntot = 0;
  int npass = 0;
  int seq = 100;

  always #5 clk = ~clk;

  uc_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .pe_imply_valid(iv), .pe_imply_lit(il), .pe_conflict(ic), .pe_imply_ready(rdy),
    .dec_lit(dl), .dec_valid(dv), .dec_ready(dr),
    .ucarb2bcp_newLit(nl), .ucarb2bcp_newLitValid(nlv), .bcp2ucarb_newLitAccept(acc),
    .flush(fl), .conflict_o(conf), .ucq_count(cnt)
  );

  assign dut_vec = {nlv, nl, cnt, conf, rdy, dr};

  function automatic logic [27:0] exp_vec();
    logic [N-1:0] r;
    r = ~mpv & {N{~mconf}};
    return {mq.size() > 0 && !mconf, mq.size() > 0 ? mq[0] : lit_t'(0), 5'(mq.size()), mconf, r,
            !(|mpv) && mq.size() < D && !mconf};
  endfunction

  // one clock of the queue semantics: flush, then grant/decision, dedup, conflict, pop/push, capture
  task automatic model_tick();
    bit pop, full, confin, candv, neg;
    logic [N-1:0] mrdy;
    lit_t cand;
    int win;
    pop = mq.size() > 0 && !mconf && acc == 4'hf;
    full = mq.size() == D;
    if (fl) begin
      mq.delete(); mpv = '0; mconf = 0; mrr = 0;
      return;
    end
    mrdy = ~mpv & {N{~mconf}};
    confin = |ic;
    candv = 0; neg = 0; cand = 0; win = 0;
    if (|mpv && (!full || pop) && !mconf) begin
      for (int k = 0; k < N; k++) if (mpv[(mrr + k) % N]) begin win = (mrr + k) % N; break; end
      cand = mpl[win]; mpv[win] = 0; mrr = (win + 1) % N; candv = 1;
    end else if (!(|mpv) && !full && !mconf && dv && dl != 0) begin
      cand = dl; candv = 1;
    end
`ifdef UCARB_DEDUP_EN
    if (candv) begin
      foreach (mq[i]) if (mq[i] == -cand) neg = 1;
      foreach (mq[i]) if (mq[i] == cand) candv = 0;
      if (neg) begin confin = 1; candv = 0; end
    end
`endif
    if (mconf || confin) begin
      mconf = 1; mq.delete(); mpv = '0;
      return;
    end
    if (pop) void'(mq.pop_front());
    if (candv) mq.push_back(cand);
    for (int i = 0; i < N; i++) if (iv[i] && mrdy[i] && il[i] != 0) begin mpv[i] = 1; mpl[i] = il[i]; end
  endtask

  task automatic idle();
    iv = '0; ic = '0; dv = 0; dl = 0; fl = 0;
    for (int i = 0; i < N; i++) il[i] = 0;
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); acc = '0;
    mq.delete(); mpv = '0; mrr = 0; mconf = 0;
    #12;
    ntot++;
    if (dut_vec !== {1'b0, 16'h0, 5'd0, 1'b0, 4'b1111, 1'b0}) $display("FAIL reset got=%h exp=%h", dut_vec, 28'h000001e);
    else npass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ntot++;
    if (dut_vec !== exp_vec()) $display("FAIL post_reset got=%h exp=%h", dut_vec, exp_vec());
    else npass++;
  endtask

  task automatic test_single();
    acc = 4'hf; idle();
    iv[1] = 1; il[1] = 5;
    step(); idle();
    ntot++;
    if (nlv !== 1'b0 || rdy !== 4'b1101) $display("FAIL single_t1 nlv=%b rdy=%b exp nlv=0 rdy=1101", nlv, rdy);
    else npass++;
    step();
    ntot++;
    if (nlv !== 1'b1 || nl !== 16'sd5) $display("FAIL single_t2 nlv=%b lit=%0d exp nlv=1 lit=5", nlv, nl);
    else npass++;
    step();
    ntot++;
    if (nlv !== 1'b0 || cnt !== 5'd0) $display("FAIL single_t3 nlv=%b cnt=%0d exp nlv=0 cnt=0", nlv, cnt);
    else npass++;
  endtask

  task automatic test_rr_order();
    logic [3:0] er [5];
    int eo [4];
    er = '{4'b0000, 4'b0100, 4'b1100, 4'b1101, 4'b1111};
    eo = '{3, 4, 1, 2};
    acc = 4'hf; idle();
    iv = 4'hf;
    for (int i = 0; i < N; i++) il[i] = lit_t'(i + 1);
    step(); idle();
    for (int c = 1; c <= 5; c++) begin
      ntot++;
      if (rdy !== er[c-1]) $display("FAIL rr_ready c=%0d got=%b exp=%b", c, rdy, er[c-1]);
      else npass++;
      if (c >= 2) begin
        ntot++;
        if (nlv !== 1'b1 || nl !== lit_t'(eo[c-2])) $display("FAIL rr_order c=%0d nlv=%b lit=%0d exp=%0d", c, nlv, nl, eo[c-2]);
        else npass++;
      end
      step();
    end
  endtask

  task automatic test_full();
    int n;
    acc = 4'b0100; idle();
    n = 0;
    while (!(mq.size() == D && mpv == 4'b1110) && n < 60) begin
      iv = 4'b1110;
      for (int i = 1; i < N; i++) il[i] = lit_t'(seq++);
      step(); n++;
      ntot++;
      if (dut_vec !== exp_vec()) $display("FAIL fill n=%0d got=%h exp=%h", n, dut_vec, exp_vec());
      else npass++;
    end
    idle();
    ntot++;
    if (cnt !== 5'd16 || rdy !== 4'b0001) $display("FAIL full_state cnt=%0d rdy=%b exp cnt=16 rdy=0001", cnt, rdy);
    else npass++;
    acc = 4'hf;
    iv[0] = 1; il[0] = 9;
    step(); idle();
    ntot++;
    if (cnt !== 5'd16 || nlv !== 1'b1) $display("FAIL full_pushpop cnt=%0d nlv=%b exp cnt=16", cnt, nlv);
    else npass++;
    for (int k = 0; k < 3; k++) begin
      step();
      ntot++;
      if (cnt !== 5'd16 || dut_vec !== exp_vec()) $display("FAIL full_hold k=%0d cnt=%0d got=%h exp=%h", k, cnt, dut_vec, exp_vec());
      else npass++;
    end
    n = 0;
    while (mq.size() > 0 && n < 40) begin
      step(); n++;
      ntot++;
      if (dut_vec !== exp_vec()) $display("FAIL drain n=%0d got=%h exp=%h", n, dut_vec, exp_vec());
      else npass++;
    end
    ntot++;
    if (cnt !== 5'd0) $display("FAIL drained cnt=%0d exp=0", cnt);
    else npass++;
  endtask

  task automatic test_conflict();
    int n;
    acc = '0; idle();
    n = 0;
    while (mq.size() < 5 && n < 30) begin
      iv = 4'b0111;
      for (int i = 0; i < 3; i++) il[i] = lit_t'(seq++);
      step(); n++;
    end
    idle();
    ntot++;
    if (cnt !== 5'd5) $display("FAIL conf_pre cnt=%0d exp=5", cnt);
    else npass++;
    ic[3] = 1;
    step(); idle();
    ntot++;
    if (conf !== 1'b1 || cnt !== 5'd0 || nlv !== 1'b0 || rdy !== 4'b0000 || dr !== 1'b0)
      $display("FAIL conf_set conf=%b cnt=%0d nlv=%b rdy=%b dr=%b exp 1/0/0/0000/0", conf, cnt, nlv, rdy, dr);
    else npass++;
    iv = 4'hf; il[0] = 3;
    step(); idle();
    ntot++;
    if (conf !== 1'b1 || cnt !== 5'd0) $display("FAIL conf_sticky conf=%b cnt=%0d exp conf=1 cnt=0", conf, cnt);
    else npass++;
    fl = 1;
    step(); idle();
    ntot++;
    if (conf !== 1'b0 || rdy !== 4'b1111 || cnt !== 5'd0) $display("FAIL conf_flush conf=%b rdy=%b cnt=%0d exp 0/1111/0", conf, rdy, cnt);
    else npass++;
  endtask

  task automatic test_decision();
    idle(); fl = 1; step(); idle();
    acc = '0;
    iv[0] = 1; il[0] = 8;
    step(); idle();
    dv = 1; dl = -7;
    ntot++;
    if (dr !== 1'b0) $display("FAIL dec_blocked dr=%b exp=0", dr);
    else npass++;
    step();
    ntot++;
    if (dr !== 1'b1 || cnt !== 5'd1 || nl !== 16'sd8) $display("FAIL dec_after dr=%b cnt=%0d lit=%0d exp 1/1/8", dr, cnt, nl);
    else npass++;
    step();
    dl = 0;
    ntot++;
    if (cnt !== 5'd2 || nl !== 16'sd8) $display("FAIL dec_enq cnt=%0d lit=%0d exp 2/8", cnt, nl);
    else npass++;
    step(); idle();
    ntot++;
    if (cnt !== 5'd2) $display("FAIL dec_zero cnt=%0d exp=2", cnt);
    else npass++;
    acc = 4'hf; step(); acc = '0;
    ntot++;
    if (cnt !== 5'd1 || nl !== -16'sd7) $display("FAIL dec_head cnt=%0d lit=%0d exp 1/-7", cnt, nl);
    else npass++;
  endtask

  task automatic test_dedup();
    idle(); fl = 1; step(); idle();
    acc = '0;
    iv[0] = 1; il[0] = 4; step(); idle(); step();
    ntot++;
    if (cnt !== 5'd1) $display("FAIL dedup_pre cnt=%0d exp=1", cnt);
    else npass++;
    iv[1] = 1; il[1] = 4; step(); idle(); step();
    ntot++;
`ifdef UCARB_DEDUP_EN
    if (cnt !== 5'd1 || conf !== 1'b0) $display("FAIL dedup_same cnt=%0d conf=%b exp 1/0", cnt, conf);
`else
    if (cnt !== 5'd2 || conf !== 1'b0) $display("FAIL dedup_same cnt=%0d conf=%b exp 2/0", cnt, conf);
`endif
    else npass++;
    iv[2] = 1; il[2] = -4; step(); idle(); step();
    ntot++;
`ifdef UCARB_DEDUP_EN
    if (conf !== 1'b1 || cnt !== 5'd0) $display("FAIL dedup_neg conf=%b cnt=%0d exp 1/0", conf, cnt);
`else
    if (conf !== 1'b0 || cnt !== 5'd3) $display("FAIL dedup_neg conf=%b cnt=%0d exp 0/3", conf, cnt);
`endif
    else npass++;
    fl = 1; step(); idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      iv = 4'($urandom);
      for (int i = 0; i < N; i++) il[i] = lit_t'(int'($urandom_range(0, 12)) - 6);
      ic = ($urandom_range(0, 79) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      acc = $urandom_range(0, 1) ? 4'hf : 4'($urandom);
      dv = 1'($urandom);
      dl = lit_t'(int'($urandom_range(0, 12)) - 6);
      fl = $urandom_range(0, 29) == 0;
      step();
      ntot++;
      if (dut_vec !== exp_vec()) $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      else npass++;
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_full();
    test_conflict();
    test_decision();
    test_dedup();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
